// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter PUF block and its challenge/response harvester.
package puf_pkg;

    localparam int         C_LENGTH  = 8;
    // Feedback taps c[7], c[5], c[4], c[3] of the 8-bit Fibonacci LFSR.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_FIRE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_VOTE   = 3'd5,
        ST_OUT    = 3'd6
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] c);
        return {c[6:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// 8-bit Fibonacci LFSR challenge generator with load, zero-seed substitution and step enable.
module puf_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_step,
    output logic [7:0] o_value
);
    import puf_pkg::*;

    logic [7:0] r_value;

    // An all-zero state would lock the LFSR, so a zero load falls back to SEED.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_value <= SEED;
        end else if (i_load) begin
            r_value <= (i_seed == 8'd0) ? SEED : i_seed;
        end else if (i_step) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/puf_response_collector.sv
// Drives challenges and excitation pulses into the arbiter PUF, majority-votes the
// synchronised response per challenge and packs eight voted bits into a byte.
// Output handshake: resp_byte transfers on a cycle where resp_valid & resp_ready;
// resp_valid stays high and resp_byte stays unchanged until that cycle.
module puf_response_collector #(
    parameter int         C_LENGTH = puf_pkg::C_LENGTH,
    parameter int         VOTES    = 5,
    parameter int         SETTLE   = 4,
    parameter logic [7:0] SEED     = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                seed_load,
    input  logic [7:0]          seed,
    output logic [C_LENGTH-1:0] challenge,
    output logic                excite,
    input  logic                response,
    output logic [7:0]          resp_byte,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                busy,
    output logic [2:0]          dbg_state
);
    import puf_pkg::*;

    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [3:0]      VOTE_LAST   = 4'(VOTES - 1);
    localparam logic [3:0]      MAJORITY    = 4'(VOTES / 2);

    state_t        r_state;
    logic          r_resp_meta;
    logic          r_resp_s;
    logic [SW-1:0] r_settle_cnt;
    logic [3:0]    r_vote_cnt;
    logic [3:0]    r_ones_cnt;
    logic [2:0]    r_bit_cnt;
    logic          r_excite;
    logic          r_resp_valid;
    logic          r_busy;
    logic [7:0]    r_resp_byte;

    logic [7:0]    w_lfsr;
    logic          w_load;
    logic          w_step;

    // Seed loads land in the same edge as start, so the first challenge is the loaded seed.
    assign w_load = (r_state == ST_IDLE) && seed_load;
    assign w_step = (r_state == ST_VOTE);

    puf_lfsr #(.SEED(SEED)) u_lfsr (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_seed  (seed),
        .i_step  (w_step),
        .o_value (w_lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_resp_meta  <= 1'b0;
            r_resp_s     <= 1'b0;
            r_settle_cnt <= '0;
            r_vote_cnt   <= '0;
            r_ones_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_excite     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_byte  <= '0;
        end else begin
            r_resp_meta <= response;
            r_resp_s    <= r_resp_meta;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt  <= '0;
                    r_vote_cnt <= '0;
                    r_ones_cnt <= '0;
                    if (start) begin
                        r_state <= ST_APPLY;
                        r_busy  <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    r_state  <= ST_FIRE;
                    r_excite <= 1'b1;
                end
                ST_FIRE: begin
                    r_state  <= ST_SETTLE;
                    r_excite <= 1'b0;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_ones_cnt <= r_ones_cnt + {3'b000, r_resp_s};
                    r_vote_cnt <= r_vote_cnt + 4'd1;
                    r_state    <= (r_vote_cnt < VOTE_LAST) ? ST_APPLY : ST_VOTE;
                end
                ST_VOTE: begin
                    r_resp_byte[r_bit_cnt] <= (r_ones_cnt > MAJORITY);
                    r_vote_cnt <= '0;
                    r_ones_cnt <= '0;
                    if (r_bit_cnt == 3'd7) begin
                        r_state      <= ST_OUT;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_state   <= ST_APPLY;
                    end
                end
                ST_OUT: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign challenge  = w_lfsr;
    assign excite     = r_excite;
    assign resp_byte  = r_resp_byte;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: a behavioural PUF answers each excite pulse from a
// per-byte response pattern; expected bytes and challenges come from an independent model.
module tb_puf_response_collector;

    localparam int         VOTES   = 5;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         LATENCY = 289;
    localparam int         PULSES  = 8 * VOTES;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       start      = 1'b0;
    logic       seed_load  = 1'b0;
    logic [7:0] seed       = 8'h00;
    logic       response   = 1'b0;
    logic       resp_ready = 1'b0;
    logic [7:0] challenge;
    logic       excite;
    logic [7:0] resp_byte;
    logic       resp_valid;
    logic       busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  obs_chal_q[$];
    logic [7:0]  exp_chal[8];
    logic [39:0] resp_pat = '0;
    logic [7:0]  m_lfsr   = SEED;
    int          pulse_idx  = 0;
    int          excite_cnt = 0;
    int          ex_base    = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    puf_response_collector #(
        .C_LENGTH (8),
        .VOTES    (VOTES),
        .SETTLE   (4),
        .SEED     (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .challenge  (challenge),
        .excite     (excite),
        .response   (response),
        .resp_byte  (resp_byte),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- behavioural PUF / pulse monitor ----------------
    always @(negedge clk) begin
        if (!busy) begin
            pulse_idx = 0;
        end else if (excite) begin
            if (pulse_idx == 0) obs_chal_q.delete();
            if (pulse_idx < PULSES) response = resp_pat[pulse_idx];
            obs_chal_q.push_back(challenge);
            pulse_idx  = pulse_idx + 1;
            excite_cnt = excite_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] c);
        return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    endfunction

    function automatic logic [7:0] model_vote(input logic [39:0] p);
        logic [7:0] r;
        int cnt;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            cnt = 0;
            for (int v = 0; v < VOTES; v++) cnt += int'(p[b*VOTES+v]);
            r[b] = (cnt > VOTES / 2);
        end
        return r;
    endfunction

    task automatic check_chals();
        bit stable;
        check_eq("pulse_count", obs_chal_q.size(), PULSES);
        check_eq("excite_pulses", excite_cnt - ex_base, PULSES);
        if (obs_chal_q.size() == PULSES) begin
            stable = 1'b1;
            for (int b = 0; b < 8; b++) begin
                check_eq("chal", obs_chal_q[b*VOTES], exp_chal[b]);
                for (int v = 1; v < VOTES; v++)
                    if (obs_chal_q[b*VOTES+v] !== obs_chal_q[b*VOTES]) stable = 1'b0;
            end
            check_eq("chal_stable", stable, 1);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        start      = 1'b0;
        seed_load  = 1'b0;
        resp_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_challenge", challenge, SEED);
        check_eq("rst_excite", excite, 0);
        check_eq("rst_byte", resp_byte, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", dbg_state, 0);
        exp_q.delete();
        m_lfsr = SEED;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_start(input bit ld, input logic [7:0] sv, input logic [39:0] pat);
        resp_pat = pat;
        if (ld) m_lfsr = (sv == 8'h00) ? SEED : sv;
        for (int b = 0; b < 8; b++) begin
            exp_chal[b] = m_lfsr;
            m_lfsr = model_step(m_lfsr);
        end
        exp_q.push_back(model_vote(pat));
        ex_base = excite_cnt;
        @(negedge clk);
        start     = 1'b1;
        seed_load = ld;
        seed      = sv;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic collect(input int hold, input bit chk_lat);
        int cyc;
        bit seen;
        bit stable;
        int ex0;
        logic [7:0] held;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) begin
            check_eq("timeout", 0, 1);
            return;
        end
        if (chk_lat) check_eq("latency", cyc, LATENCY);
        held   = resp_byte;
        ex0    = excite_cnt;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!resp_valid || resp_byte !== held || excite) stable = 1'b0;
        end
        if (hold > 0) begin
            check_eq("bp_stable", stable, 1);
            check_eq("bp_no_excite", excite_cnt - ex0, 0);
            check_eq("bp_busy", busy, 1);
        end
        if (exp_q.size() == 0) check_eq("exp_q_empty", 0, 1);
        else                   check_eq("byte", resp_byte, exp_q.pop_front());
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check_eq("busy_drop", busy, 0);
        check_eq("valid_drop", resp_valid, 0);
        check_chals();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] seq[5];
        int         cyc;
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h11;

        do_reset();

        // Reset in the middle of a vote discards the partial byte.
        do_start(1'b0, 8'h00, '0);
        repeat (100) @(negedge clk);
        do_reset();

        // Load 0x01 together with start, response tied low.
        do_start(1'b1, 8'h01, '0);
        check_eq("first_chal", challenge, 8'h01);
        collect(0, 1'b1);
        if (obs_chal_q.size() == PULSES)
            for (int i = 0; i < 5; i++) check_eq("chal_seq", obs_chal_q[i*VOTES], seq[i]);

        // Stuck-at-one response.
        do_start(1'b0, 8'h00, '1);
        collect(0, 1'b1);

        // Majority: bit 0 sees 3 of 5 ones, bit 1 sees 2 of 5.
        do_start(1'b0, 8'h00, 40'h00_0000_00D5);
        collect(0, 1'b1);

        // Backpressure on a random pattern.
        do_start(1'b0, 8'h00, {8'($urandom), 32'($urandom)});
        collect(50, 1'b1);

        // start and seed_load while busy must be ignored.
        do_start(1'b0, 8'h00, {8'($urandom), 32'($urandom)});
        repeat ($urandom_range(10, 200)) @(negedge clk);
        start     = 1'b1;
        seed_load = 1'b1;
        seed      = 8'h33;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
        collect(0, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("idle_after", busy, 0);

        // Zero seed load falls back to SEED.
        @(negedge clk);
        seed_load = 1'b1;
        seed      = 8'h00;
        @(negedge clk);
        seed_load = 1'b0;
        check_eq("zero_seed", challenge, SEED);
        m_lfsr = SEED;

        // Reset while the byte is being offered, then a fresh byte.
        do_start(1'b0, 8'h00, {8'($urandom), 32'($urandom)});
        cyc = 0;
        while (!resp_valid && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("out_reached", resp_valid, 1);
        do_reset();
        do_start(1'b0, 8'h00, {8'($urandom), 32'($urandom)});
        collect(0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
